// File: rtl/pkt_stream_arb.sv
// Packet-level round-robin arbiter: grants whole packets from N byte streams onto
// one shared stream, with a start timeout, a length watchdog and a fixed gap.
//   state | meaning
//   IDLE  | no owner, arbitrate pending requests from ptr
//   GRANT | port granted, waiting for its first byte (timer running)
//   PASS  | forwarding the granted port's packet
//   GAP   | forced idle on vout between packets
module pkt_stream_arb #(
    parameter int N        = 4,
    parameter int IFG      = 12,
    parameter int START_TO = 16,
    parameter int MAX_LEN  = 1518
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           vin,
    input  logic [N-1:0][7:0]      din,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N)-1:0]   sel,
    output logic                   busy,
    output logic                   vout,
    output logic [7:0]             dout,
    output logic                   err_to,
    output logic                   err_len
);
    localparam int SW = $clog2(N);
    localparam int TW = $clog2(START_TO + 1);
    localparam int GW = (IFG > 0) ? $clog2(IFG + 1) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(START_TO - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((IFG > 0) ? IFG - 1 : 0);
    localparam logic [15:0]   LEN_MAX   = 16'(MAX_LEN);
    localparam logic [SW-1:0] LAST_PORT = SW'(N - 1);

    typedef enum logic [1:0] {IDLE, GRANT, PASS, GAP} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   ptr, ptr_nxt, sel_nxt, sel_inc;
    logic [SW-1:0]   pick, idx;
    logic            found;
    logic [N-1:0]    gnt_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [15:0]     byte_cnt, byte_cnt_nxt;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic            vout_nxt, err_to_nxt, err_len_nxt;
    logic [7:0]      dout_nxt;
    logic            vin_sel;
    logic [7:0]      din_sel;

    assign vin_sel = vin[sel];
    assign din_sel = din[sel];
    assign sel_inc = (sel == LAST_PORT) ? '0 : sel + 1'b1;
    assign busy    = (state != IDLE);

    // First pending request at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = SW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        sel_nxt      = sel;
        gnt_nxt      = gnt;
        timer_nxt    = timer;
        byte_cnt_nxt = byte_cnt;
        gap_cnt_nxt  = gap_cnt;
        vout_nxt     = 1'b0;
        dout_nxt     = 8'h00;
        err_to_nxt   = 1'b0;
        err_len_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = GRANT;
                    sel_nxt       = pick;
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    timer_nxt     = '0;
                    byte_cnt_nxt  = '0;
                end
            end
            GRANT: begin
                if (vin_sel) begin
                    state_nxt    = PASS;
                    byte_cnt_nxt = 16'd1;
                    vout_nxt     = 1'b1;
                    dout_nxt     = din_sel;
                end else if (timer == TO_LAST) begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    err_to_nxt = 1'b1;
                    ptr_nxt    = sel_inc;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            PASS: begin
                if (vin_sel && byte_cnt != LEN_MAX) begin
                    byte_cnt_nxt = byte_cnt + 1'b1;
                    vout_nxt     = 1'b1;
                    dout_nxt     = din_sel;
                end else begin
                    // Either a normal end, or a byte past MAX_LEN that is dropped.
                    err_len_nxt = vin_sel;
                    gnt_nxt     = '0;
                    ptr_nxt     = sel_inc;
                    gap_cnt_nxt = '0;
                    state_nxt   = (IFG == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
                else                     gap_cnt_nxt = gap_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            gnt      <= '0;
            timer    <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            vout     <= 1'b0;
            dout     <= 8'h00;
            err_to   <= 1'b0;
            err_len  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            gnt      <= gnt_nxt;
            timer    <= timer_nxt;
            byte_cnt <= byte_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            vout     <= vout_nxt;
            dout     <= dout_nxt;
            err_to   <= err_to_nxt;
            err_len  <= err_len_nxt;
        end
    end
endmodule

// File: tb/tb_pkt_stream_arb.sv
// Bench for pkt_stream_arb: per-port packet sources, a byte scoreboard and a
// cycle-timeline reference model of grants, gaps and error pulses.
module tb_pkt_stream_arb;
    localparam int N        = 4;
    localparam int IFG      = 12;
    localparam int START_TO = 16;
    localparam int MAX_LEN  = 32;
    localparam int SW       = $clog2(N);

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req, vin;
    logic [N-1:0][7:0]  din;
    logic [N-1:0]       gnt;
    logic [SW-1:0]      sel;
    logic               busy, vout, err_to, err_len;
    logic [7:0]         dout;

    pkt_stream_arb #(.N(N), .IFG(IFG), .START_TO(START_TO), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .vin(vin), .din(din),
        .gnt(gnt), .sel(sel), .busy(busy), .vout(vout), .dout(dout),
        .err_to(err_to), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    // Source state per port: 0 idle, 1 requesting, 2 granted/waiting, 3 sending.
    int         p_st[N];
    int         p_len[N];
    int         p_dly[N];
    int         p_cnt[N];
    int         p_idx[N];
    logic [7:0] p_base[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_pkt(input int i, input int len, input int dly);
        logic [SW-1:0] pi;
        pi = SW'(i);
        p_st[pi]   = 1;
        p_len[pi]  = len;
        p_dly[pi]  = dly;
        p_base[pi] = 8'($urandom);
        req[pi]    = 1'b1;
    endtask

    task automatic drive_cycle();
        logic [SW-1:0] pi;
        int keep;
        for (int i = 0; i < N; i++) begin
            pi = SW'(i);
            if (p_st[pi] == 1 && gnt[pi]) begin
                p_st[pi]  = 2;
                p_cnt[pi] = 0;
            end
            if (p_st[pi] == 2) begin
                if (!gnt[pi]) p_st[pi] = 0;
                else if (p_cnt[pi] == p_dly[pi]) begin
                    p_st[pi]  = 3;
                    p_idx[pi] = 0;
                    keep = (p_len[pi] < MAX_LEN) ? p_len[pi] : MAX_LEN;
                    for (int k = 0; k < keep; k++) exp_q.push_back(p_base[pi] + 8'(k));
                end else p_cnt[pi]++;
            end
            if (p_st[pi] == 3) begin
                if (p_idx[pi] < p_len[pi]) begin
                    vin[pi] = 1'b1;
                    din[pi] = p_base[pi] + 8'(p_idx[pi]);
                    p_idx[pi]++;
                end else begin
                    p_st[pi] = 0;
                    vin[pi]  = 1'b0;
                    din[pi]  = 8'h00;
                end
            end else if (p_st[pi] == 2) begin
                vin[pi] = 1'b0;
                din[pi] = 8'h00;
            end else begin
                // Ports without the grant drive junk that must be ignored.
                vin[pi] = ($urandom_range(0, 3) == 0);
                din[pi] = 8'($urandom);
            end
            req[pi] = (p_st[pi] == 1);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            drive_cycle();
        end
    endtask

    function automatic int ports_active();
        int c = 0;
        for (int i = 0; i < N; i++) if (p_st[SW'(i)] != 0) c++;
        return c;
    endfunction

    // Reference model: owner, start of grant, start of data, first cycle arbitration may run.
    int m_owner, m_ptr, m_gstart, m_sstart, m_free_at, cyc;
    logic [N-1:0]  e_gnt;
    logic [SW-1:0] e_sel;
    logic          e_vout, e_busy, e_errto, e_errlen;
    logic          n_vout, n_errto, n_errlen;
    logic [SW-1:0] m_idx;

    task automatic release_grant(input int t);
        m_ptr     = (m_owner + 1) % N;
        m_owner   = -1;
        m_free_at = t;
    endtask

    initial begin
        e_gnt = '0; e_sel = '0; e_vout = 1'b0; e_busy = 1'b0; e_errto = 1'b0; e_errlen = 1'b0;
        m_owner = -1; m_ptr = 0; m_free_at = 0; m_gstart = 0; m_sstart = -1; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_gnt", gnt, 0);
                chk("rst_vout", vout, 0);
                chk("rst_busy", busy, 0);
                chk("rst_err", {err_to, err_len}, 0);
                m_owner = -1; m_ptr = 0; m_free_at = 0;
                e_gnt = '0; e_sel = '0; e_vout = 1'b0; e_busy = 1'b0; e_errto = 1'b0; e_errlen = 1'b0;
            end else begin
                chk("gnt", gnt, e_gnt);
                chk("busy", busy, e_busy);
                chk("vout", vout, e_vout);
                chk("err_to", err_to, e_errto);
                chk("err_len", err_len, e_errlen);
                if (e_gnt != '0) chk("sel", sel, e_sel);
                if (vout) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL dout: byte %0h with nothing expected at %0t", dout, $time);
                    end else chk("dout", dout, exp_q.pop_front());
                end else chk("dout_idle", dout, 0);

                n_vout = 1'b0; n_errto = 1'b0; n_errlen = 1'b0;
                if (m_owner < 0) begin
                    if (cyc >= m_free_at && req != '0) begin
                        for (int k = 0; k < N; k++) begin
                            m_idx = SW'((m_ptr + k) % N);
                            if (m_owner < 0 && req[m_idx]) m_owner = int'(m_idx);
                        end
                        m_gstart = cyc + 1;
                        m_sstart = -1;
                    end
                end else begin
                    m_idx = SW'(m_owner);
                    if (m_sstart < 0) begin
                        if (vin[m_idx]) begin
                            m_sstart = cyc;
                            n_vout   = 1'b1;
                        end else if (cyc - m_gstart + 1 >= START_TO) begin
                            n_errto = 1'b1;
                            release_grant(cyc + 1);
                        end
                    end else if (vin[m_idx] && (cyc - m_sstart) < MAX_LEN) begin
                        n_vout = 1'b1;
                    end else begin
                        n_errlen = vin[m_idx];
                        release_grant(cyc + 1 + IFG);
                    end
                end
                e_gnt    = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
                if (m_owner >= 0) e_sel = SW'(m_owner);
                e_busy   = (m_owner >= 0) || (cyc + 1 < m_free_at);
                e_vout   = n_vout;
                e_errto  = n_errto;
                e_errlen = n_errlen;
            end
        end
    end

    initial begin
        int seen;
        int guard;
        rst_n = 1'b0; req = '0; vin = '0; din = '0;
        for (int i = 0; i < N; i++) begin
            p_st[SW'(i)] = 0; p_len[SW'(i)] = 0; p_dly[SW'(i)] = 0;
            p_cnt[SW'(i)] = 0; p_idx[SW'(i)] = 0; p_base[SW'(i)] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        start_pkt(0, 20, 0);
        run(80);
        for (int i = 0; i < N; i++) start_pkt(i, 8, $urandom_range(0, 3));
        run(200);
        start_pkt(1, 5, 0);
        run(40);
        start_pkt(0, 6, 0);
        start_pkt(3, 6, 1);
        run(120);
        start_pkt(2, 4, 1000);
        run(1);
        start_pkt(3, 4, 0);
        run(80);
        start_pkt(1, 40, 0);
        run(100);

        repeat (4000) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++)
                if (p_st[SW'(i)] == 0 && $urandom_range(0, 15) == 0)
                    start_pkt(i, $urandom_range(1, 40),
                              ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 4));
            drive_cycle();
        end
        run(400);
        chk("drain_ports", ports_active(), 0);
        chk("drain_bytes", exp_q.size(), 0);

        // Asynchronous reset in the middle of a packet.
        start_pkt(1, 30, 0);
        seen = 0;
        guard = 0;
        while (seen < 10 && guard < 300) begin
            @(posedge clk);
            #2;
            drive_cycle();
            if (vout) seen++;
            guard++;
        end
        chk("reset_wait", seen, 10);
        #1 rst_n = 1'b0;
        #1;
        chk("async_vout", vout, 0);
        chk("async_gnt", gnt, 0);
        chk("async_busy", busy, 0);
        chk("async_dout", dout, 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) p_st[SW'(i)] = 0;
        req = '0; vin = '0; din = '0;
        start_pkt(2, 5, 0);
        start_pkt(0, 5, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive_cycle();
        run(150);
        chk("final_ports", ports_active(), 0);
        chk("final_bytes", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pkt_stream_arb.md
Name: pkt_stream_arb

Overview:
- Packet-level round-robin arbiter sharing one byte stream (valid + 8-bit data) among N requesters.
- Its output feeds a single MAC TX path; the same stream is also the tap point for the simulation packet dumper.
- Grants whole packets only: no interleaving, fixed inter-packet gap.
- Includes a start-of-packet timeout and a maximum-length watchdog so that a misbehaving source cannot stall the shared stream.

Parameters:
- N, 4, number of requesting ports (2..16).
- IFG, 12, idle cycles forced on vout between packets (0 allowed).
- START_TO, 16, cycles a granted port has to raise vin before the grant is revoked (≥1).
- MAX_LEN, 1518, maximum bytes forwarded per packet (≥1, 16-bit counter).

Ports:
- clk  in  1  Single clock; all logic on its rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- req  in  N  Port i has a packet pending; held until gnt[i].
- vin  in  N  Per-port byte valid; a packet is one contiguous high run.
- din  in  N×8  Per-port data, packed [N-1:0][7:0].
- gnt  out  N  One-hot grant, high from grant until end/abort of packet.
- sel  out  $clog2(N)  Index of the current/last granted port.
- busy  out  1  High in any state other than IDLE.
- vout  out  1  Shared stream valid.
- dout  out  8  Shared stream data.
- err_to  out  1  One-cycle pulse: start timeout.
- err_len  out  1  One-cycle pulse: packet truncated at MAX_LEN.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: gnt, sel, busy, vout, dout, err_to and err_len are all 0.
  - Internal: state IDLE, round-robin pointer ptr = 0, counters 0.
  - Applies immediately, including mid-packet. No partial packet resumes after release.
- States: IDLE, GRANT, PASS, GAP.
- IDLE:
  - If any req bit is set, pick the first set bit scanning ptr, ptr+1, …, wrapping N-1→0.
  - Next edge: gnt[i]=1, sel=i, go to GRANT, clear the timer.
  - req sampled at cycle t ⇒ gnt high at cycle t+1.
- GRANT:
  - If vin[sel] is high, go to PASS and forward that byte.
  - Otherwise the timer increments. At the end of the START_TO-th grant cycle with vin still low:
    - gnt drops, err_to pulses, ptr = sel+1 mod N.
    - Go to IDLE with no gap, since no data was sent.
- PASS:
  - Each vin[sel]-high cycle increments byte_cnt.
  - vin[sel] falls: gnt drops on that edge, ptr = sel+1 mod N, go to GAP.
  - vin[sel] high with byte_cnt already = MAX_LEN: the byte is not forwarded (vout low), err_len pulses, gnt drops, ptr advances, go to GAP. A source still driving vin is ignored.
- GAP:
  - vout held low for exactly IFG cycles counted from the first vout-low cycle after the packet, then go to IDLE.
  - IFG = 0: go to IDLE directly.
  - Requests arriving during GAP are held pending; they are not lost.
- Datapath (registered, 1-cycle latency):
  - In GRANT/PASS: vout = vin[sel] delayed 1 cycle; dout = din[sel] delayed 1 cycle.
  - dout is forced to 0 whenever vout is 0.
  - Output packets are contiguous and byte-exact copies of the input.
- Ignored inputs:
  - vin/din on non-granted ports.
  - A req deasserted while in GRANT; only the timeout releases the grant.
  - vin[sel] re-rising after the packet ends (the grant is already gone).
- Simultaneous events:
  - Packet end and a new req in the same cycle: the new req is served after GAP. The new port's arbitration uses the updated ptr.
  - The port just served is eligible again only after every other requesting port.
- Counters:
  - Timer width is $clog2(START_TO+1).
  - byte_cnt saturates at MAX_LEN; no wrap.

Test Plan:
- req[0] with 64 bytes 0x00..0x3F → gnt[0] 1 cycle after req; vout high 64 cycles, 1 cycle after vin; dout sequence matches; then exactly 12 idle cycles; busy low afterwards.
- req = 4'b1111, 8-byte packets each → served in order 0,1,2,3, each separated by a 12-cycle gap; ptr wraps to 0; a re-asserted req[0] is served next.
- Port 1 just served, then req[0] and req[3] asserted together → port 3 granted first, then port 0 (wrap check).
- req[2] asserted, vin[2] never raised → gnt[2] high exactly 16 cycles, single err_to pulse, no vout activity; a pending req[3] is granted on the next cycle's arbitration.
- MAX_LEN=32, port 1 sends 40 bytes → exactly 32 bytes on vout, err_len pulse coincident with byte 33, gnt[1] drops, 12-cycle gap follows.
- rst_n pulled low at output byte 10 → vout, gnt and busy go 0 without waiting for clk; after release, req[2] and req[0] pending → port 0 granted first (ptr = 0).
